dmem_mmio: RTL and testbench

DMEM_MMIO -- requirements
Module: dmem_mmio

---
 rtl/dmem_mmio.sv | 179 +++++++++++++++++
 tb/tb_dmem_mmio.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus a small memory-mapped peripheral
// block (timer with expiry flag, 16-bit LED register) on a single CPU port.
// Loads are zero-latency; stores and all peripheral state update on clk.
module dmem_mmio #(
    parameter int RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [15:0] led,
    input  logic [7:0]  mem_sel,
    output logic [31:0] mem_data
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam logic [8:0]  RAM_DEPTH = 9'(RAM_WORDS);

    // Word addresses (byte address >> 2) of the peripheral registers
    localparam logic [29:0] W_CTRL   = 30'h0000_1FC0;
    localparam logic [29:0] W_PRESET = 30'h0000_1FC1;
    localparam logic [29:0] W_COUNT  = 30'h0000_1FC2;
    localparam logic [29:0] W_STATUS = 30'h0000_1FC3;
    localparam logic [29:0] W_LED    = 30'h0000_1FC4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2
    } state_t;

    // Storage
    logic [31:0] ram_q [RAM_WORDS];

    // Timer / peripheral registers
    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        exp_q, exp_d;
    logic [15:0] led_q, led_d;

    // Decode
    logic [29:0]   word_addr_s;
    logic          ram_hit_s;
    logic [AW-1:0] ram_idx_s;
    logic [AW-1:0] dbg_idx_s;
    logic          wr_ctrl_s;
    logic          wr_preset_s;
    logic          wr_status_s;
    logic          wr_led_s;

    // Hardware-only timer behaviour before CPU overrides
    state_t      state_hw_s;
    logic        en_hw_s;
    logic [31:0] count_hw_s;
    logic        exp_set_s;

    assign word_addr_s = aluout[31:2];
    assign ram_hit_s   = (aluout < RAM_BYTES);
    assign ram_idx_s   = aluout[AW+1:2];
    assign dbg_idx_s   = mem_sel[AW-1:0];

    assign wr_ctrl_s   = MemWrite & ~ram_hit_s & (word_addr_s == W_CTRL);
    assign wr_preset_s = MemWrite & ~ram_hit_s & (word_addr_s == W_PRESET);
    assign wr_status_s = MemWrite & ~ram_hit_s & (word_addr_s == W_STATUS);
    assign wr_led_s    = MemWrite & ~ram_hit_s & (word_addr_s == W_LED);

    assign irq = exp_q;
    assign led = led_q;

    // RAM store port; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit_s) begin
            ram_q[ram_idx_s] <= writedata;
        end
    end

    // Debug word view, out-of-range indices read as zero
    always_comb begin
        mem_data = 32'h0000_0000;
        if ({1'b0, mem_sel} < RAM_DEPTH) begin
            mem_data = ram_q[dbg_idx_s];
        end else begin
            mem_data = 32'h0000_0000;
        end
    end

    // Timer sequencing as the hardware would do it with no CPU access
    always_comb begin
        state_hw_s = state_q;
        en_hw_s    = en_q;
        count_hw_s = count_q;
        exp_set_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_hw_s = ST_IDLE;
            end
            ST_LOAD: begin
                // Uses the PRESET value held before this edge, so a PRESET
                // store landing on the LOAD edge only affects the next LOAD
                count_hw_s = preset_q;
                state_hw_s = ST_CNT;
            end
            ST_CNT: begin
                if (count_q != 32'd0) begin
                    count_hw_s = count_q - 32'd1;
                end else begin
                    exp_set_s = 1'b1;
                    if (auto_q) begin
                        state_hw_s = ST_LOAD;
                    end else begin
                        en_hw_s    = 1'b0;
                        state_hw_s = ST_IDLE;
                    end
                end
            end
            default: begin
                state_hw_s = ST_IDLE;
            end
        endcase
    end

    // Merge CPU stores over hardware updates; CPU CTRL store wins, EXP set wins
    always_comb begin
        state_d  = wr_ctrl_s ? (writedata[0] ? ST_LOAD : ST_IDLE) : state_hw_s;
        en_d     = wr_ctrl_s ? writedata[0] : en_hw_s;
        auto_d   = wr_ctrl_s ? writedata[1] : auto_q;
        count_d  = count_hw_s;
        preset_d = wr_preset_s ? writedata : preset_q;
        led_d    = wr_led_s ? writedata[15:0] : led_q;
        exp_d    = exp_set_s ? 1'b1 :
                   ((wr_status_s && writedata[0]) ? 1'b0 : exp_q);
    end

    // Peripheral state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            preset_q <= 32'h0000_0000;
            count_q  <= 32'h0000_0000;
            exp_q    <= 1'b0;
            led_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            exp_q    <= exp_d;
            led_q    <= led_d;
        end
    end

    // Zero-latency load mux; unmapped words and unused bits read zero
    always_comb begin
        readdata = 32'h0000_0000;
        if (ram_hit_s) begin
            readdata = ram_q[ram_idx_s];
        end else begin
            case (word_addr_s)
                W_CTRL:   readdata = {30'h0000_0000, auto_q, en_q};
                W_PRESET: readdata = preset_q;
                W_COUNT:  readdata = count_q;
                W_STATUS: readdata = {31'h0000_0000, exp_q};
                W_LED:    readdata = {16'h0000, led_q};
                default:  readdata = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios with hand-derived
// expectations, then randomized traffic against a cycle-level reference model.
module tb_dmem_mmio;

    localparam logic [31:0] A_CTRL = 32'h0000_7F00;
    localparam logic [31:0] A_PRE  = 32'h0000_7F04;
    localparam logic [31:0] A_CNT  = 32'h0000_7F08;
    localparam logic [31:0] A_STAT = 32'h0000_7F0C;
    localparam logic [31:0] A_LED  = 32'h0000_7F10;

    logic        clk;
    logic        rst;
    logic        MemWrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [15:0] led;
    logic [7:0]  mem_sel;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;

    // Reference model: timer mode 0 = stopped, 1 = reload pending, 2 = counting
    int          m_mode;
    bit          m_en;
    bit          m_auto;
    bit          m_exp;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic [15:0] m_led;
    logic [31:0] m_ram [256];

    dmem_mmio #(.RAM_WORDS(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .led       (led),
        .mem_sel   (mem_sel),
        .mem_data  (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_en = 1'b0; m_auto = 1'b0; m_exp = 1'b0;
        m_preset = 32'h0; m_count = 32'h0; m_led = 16'h0;
    endtask

    task automatic model_step();
        bit          expire;
        int          mode_n;
        bit          en_n;
        logic [31:0] cnt_n;
        if (!rst) begin
            model_reset();
            return;
        end
        expire = 1'b0; mode_n = m_mode; en_n = m_en; cnt_n = m_count;
        if (m_mode == 1) begin
            cnt_n = m_preset; mode_n = 2;
        end else if (m_mode == 2) begin
            if (m_count == 32'h0) begin
                expire = 1'b1;
                if (m_auto) mode_n = 1;
                else begin en_n = 1'b0; mode_n = 0; end
            end else begin
                cnt_n = m_count - 32'd1;
            end
        end
        if (MemWrite) begin
            if (aluout < 32'd1024) m_ram[aluout[9:2]] = writedata;
            else begin
                case (aluout & 32'hFFFF_FFFC)
                    A_CTRL: begin en_n = writedata[0]; m_auto = writedata[1]; mode_n = writedata[0] ? 1 : 0; end
                    A_PRE:  m_preset = writedata;
                    A_STAT: if (writedata[0]) m_exp = 1'b0;
                    A_LED:  m_led = writedata[15:0];
                    default: ;
                endcase
            end
        end
        if (expire) m_exp = 1'b1;
        m_count = cnt_n; m_mode = mode_n; m_en = en_n;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < 32'd1024) return m_ram[a[9:2]];
        case (a & 32'hFFFF_FFFC)
            A_CTRL:  return {30'h0, m_auto, m_en};
            A_PRE:   return m_preset;
            A_CNT:   return m_count;
            A_STAT:  return {31'h0, m_exp};
            A_LED:   return {16'h0, m_led};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge: DUT and model both advance, then the store strobe drops
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; aluout = a; writedata = d;
        tick();
    endtask

    task automatic set_rd(input logic [31:0] a);
        aluout = a;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] regs [5];
        regs[0] = A_CTRL; regs[1] = A_PRE; regs[2] = A_CNT; regs[3] = A_STAT; regs[4] = A_LED;
        rst = 1'b0; MemWrite = 1'b0; aluout = 32'h0; writedata = 32'h0; mem_sel = 8'h0;
        model_reset();
        #2;
        for (int i = 0; i < 5; i++) begin
            set_rd(regs[i]);
            checks++;
            if (readdata !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp %h", i, readdata, 32'h0); end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        checks++;
        if (led !== 16'h0) begin errors++; $display("FAIL reset_led got %h exp 0000", led); end
        tick(); tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ram();
        wr(32'h10, 32'hDEAD_BEEF);
        set_rd(32'h10);
        checks++;
        if (readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd10 got %h exp deadbeef", readdata); end
        set_rd(32'h13);
        checks++;
        if (readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd13 got %h exp deadbeef", readdata); end
        mem_sel = 8'd4; #1;
        checks++;
        if (mem_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_memsel got %h exp deadbeef", mem_data); end
    endtask

    task automatic test_led();
        wr(A_LED, 32'h0001_A5A5);
        checks++;
        if (led !== 16'hA5A5) begin errors++; $display("FAIL led_out got %h exp a5a5", led); end
        set_rd(A_LED);
        checks++;
        if (readdata !== 32'h0000_A5A5) begin errors++; $display("FAIL led_rd got %h exp 0000a5a5", readdata); end
    endtask

    task automatic test_oneshot();
        wr(A_STAT, 32'h1);
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (irq !== (k == 5)) begin errors++; $display("FAIL oneshot_irq_c%0d got %b exp %b", k, irq, (k == 5)); end
        end
        set_rd(A_CTRL);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL oneshot_ctrl got %h exp 0", readdata); end
        set_rd(A_CNT);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL oneshot_count got %h exp 0", readdata); end
        set_rd(A_STAT);
        checks++;
        if (readdata !== 32'h1) begin errors++; $display("FAIL oneshot_status got %h exp 1", readdata); end
        wr(A_STAT, 32'h1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_clear got %b exp 0", irq); end
    endtask

    task automatic test_preset_zero();
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h1);
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL p0_load got %b exp 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL p0_expire got %b exp 1", irq); end
        wr(A_STAT, 32'h1);
    endtask

    task automatic test_auto();
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h3);
        // expiry every 4 edges; clears at 5, 8 (coincides with expiry) and 9
        for (int k = 1; k <= 12; k++) begin
            if (k == 5 || k == 8 || k == 9) wr(A_STAT, 32'h1);
            else tick();
            checks++;
            if (irq !== (k % 4 == 0)) begin errors++; $display("FAIL auto_irq_c%0d got %b exp %b", k, irq, (k % 4 == 0)); end
        end
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
    endtask

    task automatic test_priority();
        // PRESET store on the LOAD edge does not affect the current period
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h1);
        wr(A_PRE, 32'd7);
        set_rd(A_CNT);
        checks++;
        if (readdata !== 32'd2) begin errors++; $display("FAIL pri_preset_count got %h exp 2", readdata); end
        tick(); tick(); tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pri_preset_irq got %b exp 1", irq); end
        wr(A_STAT, 32'h1);
        // CTRL store on the expiry edge keeps EN set and restarts
        wr(A_PRE, 32'd1);
        wr(A_CTRL, 32'h1);
        tick(); tick();
        wr(A_CTRL, 32'h1);
        set_rd(A_CTRL);
        checks++;
        if (readdata !== 32'h1) begin errors++; $display("FAIL pri_ctrl_en got %h exp 1", readdata); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pri_ctrl_irq got %b exp 1", irq); end
        tick();
        set_rd(A_CNT);
        checks++;
        if (readdata !== 32'd1) begin errors++; $display("FAIL pri_ctrl_reload got %h exp 1", readdata); end
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
    endtask

    task automatic test_unmapped();
        logic [31:0] cnt_exp;
        wr(A_PRE, 32'h55);
        wr(A_LED, 32'h00C3);
        cnt_exp = m_count;
        wr(32'h7F20, 32'hFFFF_FFFF);
        wr(A_CNT, 32'h1234_5678);
        wr(32'h2000, 32'hFFFF_FFFF);
        set_rd(A_PRE);
        checks++;
        if (readdata !== 32'h55) begin errors++; $display("FAIL unm_preset got %h exp 55", readdata); end
        set_rd(A_CNT);
        checks++;
        if (readdata !== cnt_exp) begin errors++; $display("FAIL unm_count got %h exp %h", readdata, cnt_exp); end
        set_rd(A_CTRL);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL unm_ctrl got %h exp 0", readdata); end
        checks++;
        if (led !== 16'h00C3) begin errors++; $display("FAIL unm_led got %h exp 00c3", led); end
        set_rd(32'h7F20);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL unm_rd7f20 got %h exp 0", readdata); end
        set_rd(32'h2000);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL unm_rd2000 got %h exp 0", readdata); end
        set_rd(32'h10);
        checks++;
        if (readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unm_ram got %h exp deadbeef", readdata); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] regs [5];
        regs[0] = A_CTRL; regs[1] = A_PRE; regs[2] = A_CNT; regs[3] = A_STAT; regs[4] = A_LED;
        wr(A_PRE, 32'd100);
        wr(A_CTRL, 32'h1);
        repeat (51) tick();
        set_rd(A_CNT);
        checks++;
        if (readdata !== 32'd50) begin errors++; $display("FAIL rmc_count50 got %h exp 32", readdata); end
        rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 5; i++) begin
            set_rd(regs[i]);
            checks++;
            if (readdata !== 32'h0) begin errors++; $display("FAIL rmc_reg%0d got %h exp 0", i, readdata); end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rmc_irq got %b exp 0", irq); end
        checks++;
        if (led !== 16'h0) begin errors++; $display("FAIL rmc_led got %h exp 0", led); end
        mem_sel = 8'd4; #1;
        checks++;
        if (mem_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rmc_ram got %h exp deadbeef", mem_data); end
        tick();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) tick();
        set_rd(A_CNT);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL rmc_count_after got %h exp 0", readdata); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rmc_irq_after got %b exp 0", irq); end
    endtask

    task automatic test_random();
        int          op;
        logic [31:0] ra;
        logic [31:0] exp_v;
        for (int w = 0; w < 16; w++) wr(32'(w * 4), $urandom);
        for (int c = 0; c < 400; c++) begin
            op = $urandom_range(0, 9);
            MemWrite = 1'b1;
            writedata = $urandom;
            case (op)
                0: begin aluout = A_CTRL; writedata = 32'($urandom_range(0, 3)); end
                1: begin aluout = A_PRE;  writedata = 32'($urandom_range(0, 5)); end
                2: aluout = A_STAT;
                3: aluout = A_LED;
                4: aluout = 32'($urandom_range(0, 63));
                5: aluout = A_CNT;
                6: aluout = ($urandom_range(0, 1) == 0) ? 32'h7F20 : 32'h2000;
                default: MemWrite = 1'b0;
            endcase
            tick();
            checks++;
            if (irq !== m_exp) begin errors++; $display("FAIL rnd_irq c%0d got %b exp %b", c, irq, m_exp); end
            checks++;
            if (led !== m_led) begin errors++; $display("FAIL rnd_led c%0d got %h exp %h", c, led, m_led); end
            case ($urandom_range(0, 6))
                0: ra = A_CTRL;
                1: ra = A_PRE;
                2: ra = A_CNT;
                3: ra = A_STAT;
                4: ra = A_LED;
                5: ra = 32'($urandom_range(0, 63));
                default: ra = 32'h7F14;
            endcase
            mem_sel = 8'($urandom_range(0, 15));
            set_rd(ra);
            exp_v = model_read(ra);
            checks++;
            if (readdata !== exp_v) begin errors++; $display("FAIL rnd_rd c%0d addr %h got %h exp %h", c, ra, readdata, exp_v); end
            checks++;
            if (mem_data !== m_ram[mem_sel]) begin errors++; $display("FAIL rnd_memsel c%0d got %h exp %h", c, mem_data, m_ram[mem_sel]); end
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led();
        test_oneshot();
        test_preset_zero();
        test_auto();
        test_priority();
        test_unmapped();
        test_reset_midcount();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
